// File: rtl/spi2dac_pkg.sv
// Shared definitions for the MCP4911 SPI DAC transmitter:
// FSM states, frame geometry, command-bit positions and the word builder.
package spi2dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2,
    ST_LOAD  = 2'd3
  } state_e;

  localparam int unsigned FRAME_BITS   = 16;
  localparam int unsigned DATA_W       = 10;
  localparam int unsigned BIT_CNT_W    = 4;

  localparam int unsigned CMD_WRITE    = 15;
  localparam int unsigned CMD_BUF      = 14;
  localparam int unsigned CMD_GA       = 13;
  localparam int unsigned CMD_SHDN     = 12;
  localparam int unsigned CMD_DATA_MSB = 11;
  localparam int unsigned CMD_DATA_LSB = 2;

  // MCP4911 write command: write, BUF, GA, SHDN-inactive, 10-bit data, two don't-care zeros.
  function automatic logic [FRAME_BITS-1:0] build_cmd(
    input logic [DATA_W-1:0] data,
    input logic              gain_1x,
    input logic              vref_buf
  );
    logic [FRAME_BITS-1:0] w;
    w = '0;
    w[CMD_WRITE] = 1'b0;
    w[CMD_BUF]   = vref_buf;
    w[CMD_GA]    = gain_1x;
    w[CMD_SHDN]  = 1'b1;
    w[CMD_DATA_MSB:CMD_DATA_LSB] = data;
    return w;
  endfunction

endpackage

// File: rtl/spi2dac_sck_halfper_timer.sv
// SCK half-period timer: counts 0..HALF_PERIOD-1 while enabled; wrap_o is a
// registered terminal-count flag, high on the cycle the count sits at HALF_PERIOD-1.
module spi2dac_sck_halfper_timer #(
  parameter int unsigned HALF_PERIOD = 25
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic clear_i,
  output logic wrap_o
);

  localparam int unsigned CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
    wrap_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign wrap_o = wrap_q;

endmodule

// File: rtl/spi2dac.sv
// MCP4911 SPI DAC transmitter: frames a 10-bit sample into a 16-bit write
// command, shifts it out MSB-first on a divided SCK, then strobes LDAC.
module spi2dac
  import spi2dac_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 25,
  parameter logic        GAIN_1X     = 1'b1,
  parameter logic        VREF_BUF    = 1'b0
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data_to_dac,
  output logic              busy,
  output logic              done,
  output logic              dac_cs,
  output logic              dac_sck,
  output logic              dac_sdi,
  output logic              dac_ld
);

  state_e                 state_q, state_d;
  logic [FRAME_BITS-1:0]  shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic                   sck_q, sck_d;
  logic                   sdi_q, sdi_d;
  logic                   cs_q, cs_d;
  logic                   ld_q, ld_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   wrap;

  spi2dac_sck_halfper_timer #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_timer (
    .clk_i   (sysclk),
    .rst_ni  (rst_n),
    .enable_i(state_q != ST_IDLE),
    .clear_i (state_q == ST_IDLE),
    .wrap_o  (wrap)
  );

  // Next-state and registered-output logic; every phase is paced by the timer wrap.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    sck_d     = sck_q;
    sdi_d     = sdi_q;
    cs_d      = cs_q;
    ld_d      = ld_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shreg_d   = build_cmd(data_to_dac, GAIN_1X, VREF_BUF);
          bit_cnt_d = '0;
          sck_d     = 1'b0;
          sdi_d     = shreg_d[FRAME_BITS-1];
          cs_d      = 1'b0;
          ld_d      = 1'b1;
          busy_d    = 1'b1;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (wrap) begin
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            // Falling edge: advance data so it has a full half-period of setup.
            sck_d   = 1'b0;
            shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
            if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1)) begin
              bit_cnt_d = '0;
              sdi_d     = 1'b0;
              cs_d      = 1'b1;
              state_d   = ST_HOLD;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
              sdi_d     = shreg_d[FRAME_BITS-1];
            end
          end
        end
      end

      ST_HOLD: begin
        if (wrap) begin
          ld_d    = 1'b0;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (wrap) begin
          ld_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      sck_q     <= 1'b0;
      sdi_q     <= 1'b0;
      cs_q      <= 1'b1;
      ld_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      sck_q     <= sck_d;
      sdi_q     <= sdi_d;
      cs_q      <= cs_d;
      ld_q      <= ld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign dac_cs  = cs_q;
  assign dac_sck = sck_q;
  assign dac_sdi = sdi_q;
  assign dac_ld  = ld_q;

endmodule
